// File: rtl/ddr_burst_responder.sv
// rtl/ddr_burst_responder.sv - bridges a burst requester onto a native DDR controller port
// One burst in flight at a time; write/read requests are arbitrated round-robin.
module ddr_burst_responder #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 28
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    init_calib_complete,
   input  logic                    wr_burst_req,
   input  logic [ADDR_WIDTH-4:0]   wr_burst_addr,
   input  logic [9:0]              wr_burst_len,
   output logic                    wr_burst_data_req,
   input  logic [DATA_WIDTH-1:0]   wr_burst_data,
   output logic                    wr_burst_finish,
   input  logic                    rd_burst_req,
   input  logic [ADDR_WIDTH-4:0]   rd_burst_addr,
   input  logic [9:0]              rd_burst_len,
   output logic                    rd_burst_data_valid,
   output logic [DATA_WIDTH-1:0]   rd_burst_data,
   output logic                    rd_burst_finish,
   output logic                    cmd_en,
   output logic [2:0]              cmd,
   output logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    cmd_ready,
   output logic                    wr_data_en,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_data_mask,
   input  logic                    wr_data_rdy,
   input  logic                    rd_data_valid,
   input  logic [DATA_WIDTH-1:0]   rd_data
);

   localparam int BW = ADDR_WIDTH - 3;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR      = 3'd1;
   localparam logic [2:0] WR_DONE = 3'd2;
   localparam logic [2:0] RD      = 3'd3;
   localparam logic [2:0] RD_DONE = 3'd4;

   logic [2:0]    state;
   logic [BW-1:0] beat_addr;
   logic [9:0]    len_q;
   logic [9:0]    cmd_cnt;
   logic [9:0]    data_cnt;
   logic          last_rd;
   logic          in_burst;
   logic          wr_fire;
   logic          rd_fire;
   logic          go_wr;
   logic          go_rd;
   logic [9:0]    cmd_cnt_nxt;
   logic [9:0]    data_cnt_nxt;

   assign in_burst = (state == WR) || (state == RD);
   assign cmd_en   = in_burst && cmd_ready && (cmd_cnt < len_q);
   assign cmd      = (state == RD) ? 3'b001 : 3'b000;
   assign addr     = {beat_addr, 3'b000};

   // Requester FIFO is show-ahead, so its head word goes straight to the controller.
   assign wr_fire           = (state == WR) && wr_data_rdy && (data_cnt < len_q);
   assign wr_data_en        = wr_fire;
   assign wr_burst_data_req = wr_fire;
   assign wr_data           = wr_burst_data;
   assign wr_data_mask      = '0;

   // data_cnt counts write beats sent in WR and read beats received in RD.
   assign rd_fire = (state == RD) && rd_data_valid && (data_cnt < len_q);

   assign wr_burst_finish = (state == WR_DONE);
   assign rd_burst_finish = (state == RD_DONE);

   // last_rd set means the read was served last, so a tie goes to write.
   assign go_wr = init_calib_complete && wr_burst_req && (!rd_burst_req || last_rd);
   assign go_rd = init_calib_complete && rd_burst_req && !go_wr;

   assign cmd_cnt_nxt  = cmd_cnt + {9'd0, cmd_en};
   assign data_cnt_nxt = data_cnt + {9'd0, wr_fire | rd_fire};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat_addr <= '0;
         len_q     <= '0;
         cmd_cnt   <= '0;
         data_cnt  <= '0;
         last_rd   <= 1'b1;
      end else begin
         if (cmd_en) begin
            beat_addr <= beat_addr + 1'b1;
         end
         cmd_cnt  <= cmd_cnt_nxt;
         data_cnt <= data_cnt_nxt;
         case (state)
            IDLE: begin
               if (go_wr || go_rd) begin
                  beat_addr <= go_wr ? wr_burst_addr : rd_burst_addr;
                  len_q     <= go_wr ? wr_burst_len : rd_burst_len;
                  cmd_cnt   <= '0;
                  data_cnt  <= '0;
                  last_rd   <= go_rd;
                  if (go_wr) begin
                     state <= (wr_burst_len == 10'd0) ? WR_DONE : WR;
                  end else begin
                     state <= (rd_burst_len == 10'd0) ? RD_DONE : RD;
                  end
               end
            end
            // Finish follows the last write beat directly, so exit on the updated counts.
            WR: begin
               if ((cmd_cnt_nxt == len_q) && (data_cnt_nxt == len_q)) begin
                  state <= WR_DONE;
               end
            end
            // Read finish must trail the registered last beat, so exit on the current counts.
            RD: begin
               if ((cmd_cnt == len_q) && (data_cnt == len_q)) begin
                  state <= RD_DONE;
               end
            end
            WR_DONE: state <= IDLE;
            RD_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_burst_data_valid <= 1'b0;
         rd_burst_data       <= '0;
      end else begin
         rd_burst_data_valid <= rd_fire;
         if (rd_fire) begin
            rd_burst_data <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_ddr_burst_responder.sv
// tb/tb_ddr_burst_responder.sv - directed bench for ddr_burst_responder
// Drives inputs on the falling edge and samples 1 time unit later.
module tb_ddr_burst_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         init_calib_complete;
   logic         wr_burst_req;
   logic [24:0]  wr_burst_addr;
   logic [9:0]   wr_burst_len;
   logic         wr_burst_data_req;
   logic [255:0] wr_burst_data;
   logic         wr_burst_finish;
   logic         rd_burst_req;
   logic [24:0]  rd_burst_addr;
   logic [9:0]   rd_burst_len;
   logic         rd_burst_data_valid;
   logic [255:0] rd_burst_data;
   logic         rd_burst_finish;
   logic         cmd_en;
   logic [2:0]   cmd;
   logic [27:0]  addr;
   logic         cmd_ready;
   logic         wr_data_en;
   logic [255:0] wr_data;
   logic [31:0]  wr_data_mask;
   logic         wr_data_rdy;
   logic         rd_data_valid;
   logic [255:0] rd_data;

   ddr_burst_responder #(.DATA_WIDTH(256), .ADDR_WIDTH(28)) dut (
      .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
      .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
      .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
      .wr_burst_finish(wr_burst_finish),
      .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
      .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
      .rd_burst_finish(rd_burst_finish),
      .cmd_en(cmd_en), .cmd(cmd), .addr(addr), .cmd_ready(cmd_ready),
      .wr_data_en(wr_data_en), .wr_data(wr_data), .wr_data_mask(wr_data_mask),
      .wr_data_rdy(wr_data_rdy), .rd_data_valid(rd_data_valid), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Observations gathered by the burst driver, checked by each test.
   bit          rnd_rdy;
   int          drop_at;
   logic [24:0] w_base, r_base;
   int          w_len, r_len;
   int          w_cmd_b, w_dat_b, r_cmd_b, r_rcv_b;
   int          w_cmd_tot, w_dat_tot, r_cmd_tot, r_rcv_tot;
   int          w_bad, r_bad, w_fin, r_fin, w_fin_ok, r_fin_ok;
   int          w_last, r_last, w_gap, r_gap;
   int          r_pend, r_sent, seq, timeouts, stray;
   bit          prev_v, drv_v;
   logic [27:0] exp_a;

   task automatic clear_stats();
      w_cmd_b = 0; w_dat_b = 0; r_cmd_b = 0; r_rcv_b = 0;
      w_cmd_tot = 0; w_dat_tot = 0; r_cmd_tot = 0; r_rcv_tot = 0;
      w_bad = 0; r_bad = 0; w_fin = 0; r_fin = 0; w_fin_ok = 0; r_fin_ok = 0;
      w_last = 0; r_last = 0; w_gap = -1; r_gap = -1;
      r_pend = 0; r_sent = 0; seq = 0; timeouts = 0; stray = 0;
      prev_v = 1'b0; drop_at = -1; rnd_rdy = 1'b0;
   endtask

   task automatic run_cycles(input int nfin, input int max_cyc);
      int cyc = 0;
      int fins = 0;
      while (fins < nfin && cyc < max_cyc) begin
         @(negedge clk);
         if (cyc == drop_at) begin
            wr_burst_req = 1'b0;
            rd_burst_req = 1'b0;
            init_calib_complete = 1'b0;
         end
         cmd_ready   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_data_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int i = 0; i < 8; i++) wr_burst_data[i*32 +: 32] = $urandom;
         drv_v = (r_pend > 0) && (!rnd_rdy || ($urandom_range(0, 2) != 0));
         rd_data_valid = drv_v;
         rd_data = {8{32'hC0DE0000 + 32'(r_sent)}};
         if (drv_v) begin
            r_pend--;
            r_sent++;
         end
         #1;
         if (cmd_en) begin
            if (cmd === 3'b000) begin
               exp_a = {w_base + 25'(w_cmd_b), 3'b000};
               if (addr !== exp_a) w_bad++;
               w_cmd_b++; w_cmd_tot++;
            end else if (cmd === 3'b001) begin
               exp_a = {r_base + 25'(r_cmd_b), 3'b000};
               if (addr !== exp_a) r_bad++;
               r_cmd_b++; r_cmd_tot++; r_pend++;
            end else begin
               w_bad++;
            end
         end
         if (wr_data_en) begin
            if (wr_burst_data_req !== 1'b1 || wr_data !== wr_burst_data || wr_data_mask !== 32'd0)
               w_bad++;
            w_dat_b++; w_dat_tot++; w_last = cyc;
         end else if (wr_burst_data_req !== 1'b0) begin
            w_bad++;
         end
         if (rd_burst_data_valid !== prev_v) r_bad++;
         if (rd_burst_data_valid === 1'b1) begin
            if (rd_burst_data !== {8{32'hC0DE0000 + 32'(r_rcv_tot)}}) r_bad++;
            r_rcv_b++; r_rcv_tot++; r_last = cyc;
         end
         if (wr_burst_finish === 1'b1) begin
            fins++; seq = seq * 10 + 1; w_fin++; w_gap = cyc - w_last;
            if (w_cmd_b == w_len && w_dat_b == w_len) w_fin_ok++;
            w_cmd_b = 0; w_dat_b = 0; wr_burst_req = 1'b0;
         end
         if (rd_burst_finish === 1'b1) begin
            fins++; seq = seq * 10 + 2; r_fin++; r_gap = cyc - r_last;
            if (r_cmd_b == r_len && r_rcv_b == r_len) r_fin_ok++;
            r_cmd_b = 0; r_rcv_b = 0; rd_burst_req = 1'b0;
         end
         prev_v = drv_v;
         cyc++;
      end
      rd_data_valid = 1'b0;
      if (fins < nfin) timeouts++;
   endtask

   task automatic idle_check(input int n, input bit rdv);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rd_data_valid = rdv;
         cmd_ready = 1'b1;
         wr_data_rdy = 1'b1;
         #1;
         if (cmd_en || wr_data_en || rd_burst_data_valid || wr_burst_finish || rd_burst_finish)
            stray++;
      end
      rd_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      wr_burst_req = 1'b0;
      rd_burst_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init_calib_complete = 1'b1;
      wr_burst_req = 1'b1; wr_burst_addr = 25'h100; wr_burst_len = 10'd8;
      rd_burst_req = 1'b1; rd_burst_addr = 25'h200; rd_burst_len = 10'd8;
      cmd_ready = 1'b1; wr_data_rdy = 1'b1; rd_data_valid = 1'b1;
      wr_burst_data = '1; rd_data = '1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({cmd_en, cmd, addr, wr_data_en, wr_data_mask, wr_burst_data_req} !== '0)
         $display("FAIL reset_cmd_outputs got %h want 0",
                  {cmd_en, cmd, addr, wr_data_en, wr_data_mask, wr_burst_data_req});
      else n_pass++;
      n_checks++;
      if ({rd_burst_data_valid, rd_burst_data, wr_burst_finish, rd_burst_finish} !== '0)
         $display("FAIL reset_rd_outputs valid=%b fin=%b%b want 0", rd_burst_data_valid,
                  wr_burst_finish, rd_burst_finish);
      else n_pass++;
      wr_burst_req = 1'b0; rd_burst_req = 1'b0; rd_data_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_64();
      clear_stats();
      w_base = 25'h100; w_len = 64;
      wr_burst_addr = w_base; wr_burst_len = 10'd64; wr_burst_req = 1'b1;
      run_cycles(1, 300);
      idle_check(3, 1'b0);
      n_checks++;
      if (w_cmd_tot != 64 || w_dat_tot != 64)
         $display("FAIL write64_counts cmd=%0d data=%0d want 64/64", w_cmd_tot, w_dat_tot);
      else n_pass++;
      n_checks++;
      if (w_bad != 0) $display("FAIL write64_addr_data errors=%0d want 0", w_bad);
      else n_pass++;
      n_checks++;
      if (w_fin != 1 || w_gap != 1 || timeouts != 0 || stray != 0)
         $display("FAIL write64_finish fin=%0d gap=%0d tmo=%0d stray=%0d want 1/1/0/0",
                  w_fin, w_gap, timeouts, stray);
      else n_pass++;
   endtask

   task automatic test_read_192();
      clear_stats();
      rnd_rdy = 1'b1;
      drop_at = 5;
      r_base = 25'h55; r_len = 192;
      rd_burst_addr = r_base; rd_burst_len = 10'd192; rd_burst_req = 1'b1;
      run_cycles(1, 3000);
      init_calib_complete = 1'b1;
      n_checks++;
      if (r_cmd_tot != 192 || r_rcv_tot != 192)
         $display("FAIL read192_counts cmd=%0d beats=%0d want 192/192", r_cmd_tot, r_rcv_tot);
      else n_pass++;
      n_checks++;
      if (r_bad != 0) $display("FAIL read192_order_latency errors=%0d want 0", r_bad);
      else n_pass++;
      n_checks++;
      if (r_fin != 1 || r_gap != 1 || timeouts != 0)
         $display("FAIL read192_finish fin=%0d gap=%0d tmo=%0d want 1/1/0", r_fin, r_gap, timeouts);
      else n_pass++;
   endtask

   task automatic test_random_ready();
      clear_stats();
      rnd_rdy = 1'b1;
      w_base = 25'h1234; w_len = 64;
      wr_burst_addr = w_base; wr_burst_len = 10'd64; wr_burst_req = 1'b1;
      run_cycles(1, 2000);
      n_checks++;
      if (w_cmd_tot != 64 || w_dat_tot != 64 || w_bad != 0)
         $display("FAIL rndrdy_counts cmd=%0d data=%0d err=%0d want 64/64/0",
                  w_cmd_tot, w_dat_tot, w_bad);
      else n_pass++;
      n_checks++;
      if (w_fin_ok != 1 || timeouts != 0)
         $display("FAIL rndrdy_finish complete_fin=%0d tmo=%0d want 1/0", w_fin_ok, timeouts);
      else n_pass++;
   endtask

   task automatic test_addr_wrap();
      clear_stats();
      w_base = 25'h1FFFFFE; w_len = 4;
      wr_burst_addr = w_base; wr_burst_len = 10'd4; wr_burst_req = 1'b1;
      run_cycles(1, 100);
      n_checks++;
      if (w_cmd_tot != 4 || w_bad != 0 || exp_a !== 28'h0000008)
         $display("FAIL addr_wrap cmds=%0d err=%0d last=%h want 4/0/0000008",
                  w_cmd_tot, w_bad, exp_a);
      else n_pass++;
   endtask

   task automatic test_arbitration();
      do_reset();
      clear_stats();
      w_base = 25'h10; w_len = 3; r_base = 25'h20; r_len = 2;
      wr_burst_addr = w_base; wr_burst_len = 10'd3;
      rd_burst_addr = r_base; rd_burst_len = 10'd2;
      wr_burst_req = 1'b1; rd_burst_req = 1'b1;
      run_cycles(2, 100);
      wr_burst_req = 1'b1; rd_burst_req = 1'b1;
      run_cycles(2, 100);
      rd_burst_req = 1'b1;
      run_cycles(1, 100);
      n_checks++;
      if (seq != 12122) $display("FAIL arb_order got %0d want 12122", seq);
      else n_pass++;
      n_checks++;
      if (w_bad != 0 || r_bad != 0 || timeouts != 0 || w_fin_ok != 2 || r_fin_ok != 3)
         $display("FAIL arb_bursts werr=%0d rerr=%0d tmo=%0d wok=%0d rok=%0d want 0/0/0/2/3",
                  w_bad, r_bad, timeouts, w_fin_ok, r_fin_ok);
      else n_pass++;
   endtask

   task automatic test_no_calib();
      clear_stats();
      w_base = 25'h40; w_len = 2; r_base = 25'h80; r_len = 2;
      wr_burst_addr = w_base; wr_burst_len = 10'd2;
      rd_burst_addr = r_base; rd_burst_len = 10'd2;
      init_calib_complete = 1'b0;
      wr_burst_req = 1'b1; rd_burst_req = 1'b1;
      idle_check(20, 1'b0);
      n_checks++;
      if (stray != 0) $display("FAIL nocalib_grant activity=%0d want 0", stray);
      else n_pass++;
      init_calib_complete = 1'b1;
      run_cycles(2, 100);
      n_checks++;
      if (seq != 12 || timeouts != 0)
         $display("FAIL nocalib_release order=%0d tmo=%0d want 12/0", seq, timeouts);
      else n_pass++;
   endtask

   task automatic test_len0();
      clear_stats();
      w_base = 25'h77; w_len = 0;
      wr_burst_addr = w_base; wr_burst_len = 10'd0; wr_burst_req = 1'b1;
      run_cycles(1, 20);
      r_base = 25'h99; r_len = 0;
      rd_burst_addr = r_base; rd_burst_len = 10'd0; rd_burst_req = 1'b1;
      run_cycles(1, 20);
      n_checks++;
      if (w_fin != 1 || w_cmd_tot != 0 || w_dat_tot != 0)
         $display("FAIL len0_write fin=%0d cmd=%0d data=%0d want 1/0/0", w_fin, w_cmd_tot, w_dat_tot);
      else n_pass++;
      n_checks++;
      if (r_fin != 1 || r_cmd_tot != 0 || timeouts != 0)
         $display("FAIL len0_read fin=%0d cmd=%0d tmo=%0d want 1/0/0", r_fin, r_cmd_tot, timeouts);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      clear_stats();
      r_base = 25'h300; r_len = 16;
      rd_burst_addr = r_base; rd_burst_len = 10'd16; rd_burst_req = 1'b1;
      run_cycles(1, 6);
      n_checks++;
      if (r_cmd_tot == 0 || r_fin != 0)
         $display("FAIL midrd_started cmds=%0d fin=%0d want >0/0", r_cmd_tot, r_fin);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b0;
      rd_burst_req = 1'b0;
      rd_data_valid = 1'b1;
      cmd_ready = 1'b1;
      #1;
      n_checks++;
      if ({cmd_en, cmd, addr, wr_data_en, wr_burst_data_req, rd_burst_data_valid,
           rd_burst_data, wr_burst_finish, rd_burst_finish} !== '0)
         $display("FAIL midrd_reset_outputs cmd_en=%b addr=%h valid=%b want 0",
                  cmd_en, addr, rd_burst_data_valid);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      idle_check(6, 1'b1);
      n_checks++;
      if (stray != 0) $display("FAIL midrd_after_reset activity=%0d want 0", stray);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_64();
      test_read_192();
      test_random_ready();
      test_addr_wrap();
      test_arbitration();
      test_no_calib();
      test_len0();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
